// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch-stage signals toward instruction memory and toward the
// IF/ID boundary.
//   master : the fetch stage (drives pc and the if_id_* outputs)
//   slave  : the surroundings (memory read data, decode stall, redirect)
// Signals:
//   pc                 address presented to instruction memory
//   instruction        memory word at the pc of the previous cycle
//   immediate          memory word at that pc + 1
//   stall              decode cannot accept; if_id_* must hold
//   redirect_en        branch/jump taken; flush and refetch
//   redirect_pc        redirect target address
//   if_id_instruction  fetched instruction
//   if_id_immediate    its immediate (meaningful for two-word instructions)
//   if_id_pc           address of if_id_instruction
//   if_id_valid        if_id_* hold a real instruction
// ----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int NUM_OF_BITS = 16,
  parameter int PC_WIDTH    = 32
);
  logic [PC_WIDTH-1:0]    pc;
  logic [NUM_OF_BITS-1:0] instruction;
  logic [NUM_OF_BITS-1:0] immediate;
  logic                   stall;
  logic                   redirect_en;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic [NUM_OF_BITS-1:0] if_id_instruction;
  logic [NUM_OF_BITS-1:0] if_id_immediate;
  logic [PC_WIDTH-1:0]    if_id_pc;
  logic                   if_id_valid;

  modport master (
    output pc,
    input  instruction, immediate, stall, redirect_en, redirect_pc,
    output if_id_instruction, if_id_immediate, if_id_pc, if_id_valid
  );

  modport slave (
    input  pc,
    output instruction, immediate, stall, redirect_en, redirect_pc,
    input  if_id_instruction, if_id_immediate, if_id_pc, if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage in front of a registered-read instruction memory.
// Issues a word address every cycle, receives the word one cycle later,
// drops the trailing immediate word of two-word instructions, absorbs decode
// stalls with a one-entry skid buffer and flushes on branch/jump redirect.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_stage_if.master (memory address/data, stall, redirect,
//          registered if_id_* outputs)
// Optional (macro FETCH_PERF_CNT_EN):
//   perf_instr_cnt   saturating count of edges loading a valid instruction
//   perf_bubble_cnt  saturating count of non-stall edges loading a bubble
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter int          NUM_OF_BITS  = 16,
  parameter int          PC_WIDTH     = 32,
  parameter int          ADDR_BITS    = 5,
  parameter int unsigned RESET_PC     = 0,
  parameter int          IMM_FLAG_BIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   perf_instr_cnt,
  output logic [15:0]   perf_bubble_cnt
`endif
);

  typedef logic [ADDR_BITS-1:0] addr_t;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [NUM_OF_BITS-1:0] instr;
    logic [NUM_OF_BITS-1:0] imm;
    addr_t                  pc;
  } word_t;

  // Only the low ADDR_BITS of every address are stored; the upper bits of
  // all address outputs are constant zero, which gives the modulo wrap.
  addr_t pc_q,         pc_d;
  logic  arr_valid_q,  arr_valid_d;
  addr_t arr_pc_q,     arr_pc_d;
  logic  skip_q,       skip_d;
  logic  skid_valid_q, skid_valid_d;
  word_t skid_q,       skid_d;
  logic  ifid_valid_q, ifid_valid_d;
  word_t ifid_q,       ifid_d;

  word_t arr_word;
  logic  consume;
  logic  deliver;
  logic  load_valid;

  // Upper redirect bits are deliberately ignored (address wraps).
  logic  unused_redirect_hi;
  assign unused_redirect_hi = ^bus.redirect_pc[PC_WIDTH-1:ADDR_BITS];

  assign arr_word = '{instr: bus.instruction, imm: bus.immediate, pc: arr_pc_q};

  // The arriving word can be taken unless a redirect flushes it, or decode is
  // stalled and the skid has no room for it.
  assign consume = arr_valid_q & ~bus.redirect_en & (~bus.stall | ~skid_valid_q);
  // A consumed word is dropped when it is the immediate of the previous one.
  assign deliver = consume & ~skip_q;

  // IF/ID receives a real instruction: the skid drains first, else the
  // delivered word goes straight through.
  assign load_valid = ~bus.redirect_en & ~bus.stall & (skid_valid_q | deliver);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // this block leaves one unassigned and no latch is inferred.
    pc_d         = pc_q;
    arr_valid_d  = arr_valid_q;
    arr_pc_d     = arr_pc_q;
    skip_d       = skip_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    ifid_valid_d = ifid_valid_q;
    ifid_d       = ifid_q;

    if (bus.redirect_en) begin
      // Redirect wins over stall: everything in flight is discarded and
      // IF/ID data fields hold under a cleared valid.
      pc_d         = bus.redirect_pc[ADDR_BITS-1:0];
      arr_valid_d  = 1'b0;
      skip_d       = 1'b0;
      skid_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
    end else begin
      arr_valid_d = 1'b1;
      arr_pc_d    = pc_q;
      // Holding pc during a stall makes the same word arrive again until the
      // stage can take it.
      if (!bus.stall) pc_d = pc_q + addr_t'(1);

      if (consume) skip_d = skip_q ? 1'b0 : bus.instruction[IMM_FLAG_BIT];

      if (bus.stall) begin
        // consume implies the skid is empty here.
        if (deliver) begin
          skid_valid_d = 1'b1;
          skid_d       = arr_word;
        end
      end else if (skid_valid_q) begin
        // Oldest word first: skid to IF/ID, new word (if any) refills skid.
        ifid_valid_d = 1'b1;
        ifid_d       = skid_q;
        skid_valid_d = deliver;
        if (deliver) skid_d = arr_word;
      end else if (deliver) begin
        ifid_valid_d = 1'b1;
        ifid_d       = arr_word;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= addr_t'(RESET_PC);
      arr_valid_q  <= 1'b0;
      arr_pc_q     <= '0;
      skip_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_q       <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      pc_q         <= pc_d;
      arr_valid_q  <= arr_valid_d;
      arr_pc_q     <= arr_pc_d;
      skip_q       <= skip_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_q       <= ifid_d;
    end
  end

  assign bus.pc                = PC_WIDTH'(pc_q);
  assign bus.if_id_valid       = ifid_valid_q;
  assign bus.if_id_instruction = ifid_q.instr;
  assign bus.if_id_immediate   = ifid_q.imm;
  assign bus.if_id_pc          = PC_WIDTH'(ifid_q.pc);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_instr_cnt_q;
  logic [15:0] perf_bubble_cnt_q;
  logic        load_bubble;

  assign load_bubble = ~bus.stall & ~load_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_cnt_q  <= '0;
      perf_bubble_cnt_q <= '0;
    end else begin
      if (load_valid && perf_instr_cnt_q != 16'hFFFF)
        perf_instr_cnt_q <= perf_instr_cnt_q + 16'd1;
      if (load_bubble && perf_bubble_cnt_q != 16'hFFFF)
        perf_bubble_cnt_q <= perf_bubble_cnt_q + 16'd1;
    end
  end

  assign perf_instr_cnt  = perf_instr_cnt_q;
  assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A 32-word registered-read memory is
// modelled next to the DUT. The reference model treats the stage as a short
// FIFO of pending instructions: each consumed, non-skipped word is pushed,
// and every non-stall edge pops one entry into IF/ID (or loads a bubble).
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int NB = 16;
  localparam int PW = 32;
  localparam int AB = 5;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst_n;

  fetch_stage_if #(.NUM_OF_BITS(NB), .PC_WIDTH(PW)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_instr_cnt;
  logic [15:0] perf_bubble_cnt;
`endif

  fetch_stage #(
    .NUM_OF_BITS(NB), .PC_WIDTH(PW), .ADDR_BITS(AB),
    .RESET_PC(0), .IMM_FLAG_BIT(15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_instr_cnt (perf_instr_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory with registered read.
  logic [NB-1:0] mem [DEPTH];

  always @(posedge clk) begin
    bus.instruction <= mem[bus.pc[AB-1:0]];
    bus.immediate   <= mem[bus.pc[AB-1:0] + 5'd1];
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [NB-1:0] instr;
    logic [NB-1:0] imm;
    int            pc;
  } ref_word_t;

  int        m_pc;       // address being issued this cycle
  bit        m_arr_v;    // a word arrives this cycle
  int        m_arr_pc;   // its address
  bit        m_skip;     // next consumed word is an immediate to drop
  ref_word_t pending[$]; // delivered but not yet shown (at most one left over)
  bit        o_valid;
  ref_word_t o_word;

  int total = 0;
  int bad   = 0;

  function automatic void model_reset();
    m_pc     = 0;
    m_arr_v  = 0;
    m_arr_pc = 0;
    m_skip   = 0;
    pending.delete();
    o_valid  = 0;
    o_word   = '{instr: '0, imm: '0, pc: 0};
  endfunction

  function automatic void model_edge(input bit st, input bit re, input logic [PW-1:0] rpc);
    ref_word_t w;
    bit        take;
    if (re) begin
      m_pc    = int'(rpc % DEPTH);
      m_arr_v = 0;
      m_skip  = 0;
      pending.delete();
      o_valid = 0;
      return;
    end
    w.instr = mem[m_arr_pc];
    w.imm   = mem[(m_arr_pc + 1) % DEPTH];
    w.pc    = m_arr_pc;
    take    = m_arr_v && (!st || pending.size() == 0);
    if (take) begin
      if (m_skip) m_skip = 0;
      else begin
        m_skip = w.instr[15];
        pending.push_back(w);
      end
    end
    if (!st) begin
      if (pending.size() > 0) begin
        o_word  = pending.pop_front();
        o_valid = 1;
      end else begin
        o_valid = 0;
      end
    end
    m_arr_pc = m_pc;
    m_arr_v  = 1;
    if (!st) m_pc = (m_pc + 1) % DEPTH;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    bus.pc,                PW'(m_pc));
    check({tag, ".valid"}, PW'(bus.if_id_valid),  PW'(o_valid));
    check({tag, ".ifpc"},  bus.if_id_pc,          PW'(o_word.pc));
    check({tag, ".instr"}, PW'(bus.if_id_instruction), PW'(o_word.instr));
    check({tag, ".imm"},   PW'(bus.if_id_immediate),   PW'(o_word.imm));
  endtask

  // Called at a negedge: drive inputs, take one edge, compare, return at the
  // next negedge.
  task automatic cycle(input string tag, input bit st, input bit re, input logic [PW-1:0] rpc);
    bus.stall       = st;
    bus.redirect_en = re;
    bus.redirect_pc = rpc;
    @(posedge clk);
    model_edge(st, re, rpc);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Called at a negedge: asserts reset without a clock edge, checks the
  // asynchronous effect, holds one edge and releases at the next negedge.
  task automatic apply_reset(input string tag);
    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom) & 16'h7FFF;

    // Straight-line one-word program, run across the address wrap.
    @(negedge clk);
    apply_reset("reset0");
    for (int i = 0; i < 36; i++) cycle("stream", 1'b0, 1'b0, '0);

    // Three-cycle stall mid-stream, then release.
    for (int i = 0; i < 3; i++) cycle("stall3", 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle("release", 1'b0, 1'b0, '0);

    // Redirect to 20 on the same edge as a stall with the skid occupied.
    cycle("pre_redir", 1'b1, 1'b0, '0);
    cycle("redir", 1'b1, 1'b1, 32'd20);
    for (int i = 0; i < 6; i++) cycle("post_redir", 1'b0, 1'b0, '0);

    // Redirect target with upper bits set wraps into the memory range.
    cycle("redir_hi", 1'b0, 1'b1, 32'hABCD_0021);
    for (int i = 0; i < 4; i++) cycle("post_hi", 1'b0, 1'b0, '0);

    // Reset during a stall with the skid full.
    cycle("fill_skid", 1'b1, 1'b0, '0);
    cycle("fill_skid", 1'b1, 1'b0, '0);
    mem[1] = 16'h8005;
    mem[2] = 16'h1234;
    mem[3] = 16'h0042;
    mem[31] = 16'h0777;
    apply_reset("reset_mid");

    // Two-word instruction at address 1: its immediate word is dropped.
    for (int i = 0; i < 8; i++) cycle("twoword", 1'b0, 1'b0, '0);
    // Stall arriving right after a two-word instruction.
    cycle("tw_stall", 1'b1, 1'b0, '0);
    cycle("tw_stall", 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle("tw_rel", 1'b0, 1'b0, '0);

    // Randomised mix of instruction kinds, stalls and redirects.
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 16'($urandom);
      mem[i][15] = ($urandom_range(0, 3) == 0);
    end
    apply_reset("reset_rand");
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 19) == 0),
            PW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the instruction memory and feeding the IF/ID boundary. It drives the word address `pc` into the memory and receives `instruction`/`immediate` one clock later, since the memory read is registered. It detects two-word (immediate-carrying) instructions and discards the trailing immediate word. It also handles decode-stage stalls with a one-entry skid buffer and flushes on branch/jump redirect, presenting registered `if_id_*` outputs to decode.

## Interface
- `NUM_OF_BITS`, 16, instruction/immediate word width
- `PC_WIDTH`, 32, width of `pc` and all address ports
- `ADDR_BITS`, 5, memory depth log2; pc wraps modulo 2**ADDR_BITS
- `RESET_PC`, 0, first fetch address after reset
- `IMM_FLAG_BIT`, 15, instruction bit which, when 1, marks a two-word instruction
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pc`  out  PC_WIDTH  address presented to instruction memory
- `instruction`  in  NUM_OF_BITS  memory word at `pc` of the previous cycle
- `immediate`  in  NUM_OF_BITS  memory word at that `pc`+1
- `stall`  in  1  decode cannot accept; hold `if_id_*`
- `redirect_en`  in  1  branch/jump taken; flush and refetch
- `redirect_pc`  in  PC_WIDTH  target address
- `if_id_instruction`  out  NUM_OF_BITS  fetched instruction
- `if_id_immediate`  out  NUM_OF_BITS  its immediate; meaningful only for two-word instructions
- `if_id_pc`  out  PC_WIDTH  address of `if_id_instruction`
- `if_id_valid`  out  1  outputs hold a real instruction

## Operation
- State:
  - `pc`
  - arrival tracker: `arr_valid` plus `arr_pc`, equal to the `pc` issued last cycle
  - `skip` flag
  - skid entry: valid, instr, imm, pc
  - IF/ID output registers
- Arrival word W = (`instruction`, `immediate`, `arr_pc`), present while `arr_valid`=1.
- W is consumed at an edge when `arr_valid` & !`redirect_en` & (!`stall` | skid empty).
- When W is consumed:
  - If `skip`=1: drop W and clear `skip`.
  - Otherwise: deliver W, then set `skip` <= W.instruction[IMM_FLAG_BIT].
- Where a delivered W goes:
  - `stall`=0, skid empty: into IF/ID.
  - `stall`=0, skid full: IF/ID takes the skid contents; W goes into the skid.
  - `stall`=1: W goes into the skid.
- IF/ID when `stall`=0 and nothing is delivered: `if_id_valid` <= 0 (bubble). Data fields hold.
- IF/ID when `stall`=1: all `if_id_*` hold.
- `pc` update:
  - `stall`=0: `pc` <= (`pc`+1) mod 2**ADDR_BITS.
  - `stall`=1: `pc` holds, so W repeats with the same `arr_pc` until consumed.
  - `arr_pc` <= `pc` and `arr_valid` <= 1 every non-redirect edge.
- Redirect has priority over stall, in the same edge:
  - `pc` <= `redirect_pc` mod 2**ADDR_BITS
  - `arr_valid` <= 0; `skip` <= 0; skid cleared; `if_id_valid` <= 0
- Two-word instruction: costs two fetch cycles. The next arriving word (the immediate itself) is dropped.
- A two-word instruction at address 2**ADDR_BITS-1 is not corrected. Its immediate is out of range, and `skip` still drops the word at wrapped address 0.
- Upper `pc` bits [PC_WIDTH-1:ADDR_BITS] are always 0.

## Timing
- Reset (async on `rst_n`=0):
  - `pc`=RESET_PC
  - `arr_valid`=0, `skip`=0, skid empty
  - `if_id_valid`=0; `if_id_instruction`, `if_id_immediate` and `if_id_pc` all 0
- Reset mid-operation discards everything in flight. There is no partial state.
- Latency: `pc` issued in cycle k → W visible in cycle k+1 → `if_id_*` valid after edge k+2.
- First valid `if_id` appears 2 edges after `rst_n` deasserts.
- Redirect asserted in cycle k: the target appears in `if_id` after edge k+3. The edge k+1 and k+2 outputs are bubbles.
- Sustained throughput with `stall`=0 and one-word instructions: 1 instruction per cycle, no bubbles.
- `stall` release with skid full: the skid word is presented on the release edge; W follows on the next edge with no bubble.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds output ports `perf_instr_cnt` [15:0] and `perf_bubble_cnt` [15:0].
  - `perf_instr_cnt` increments on each edge where `if_id_valid` becomes/stays 1 with new data.
  - `perf_bubble_cnt` increments on each non-stall edge loading `if_id_valid`=0.
  - Both counters saturate at 16'hFFFF, reset to 0 and clear on `rst_n` only.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, memory words 0..3 one-word (bit15=0), no stall → `if_id_pc` = 0,1,2,3 on consecutive edges starting 2 edges after reset release, `if_id_valid`=1 throughout.
- mem[1]=16'h8005 (two-word), mem[2]=16'h1234 → `if_id` shows pc1 with `if_id_immediate`=16'h1234, then a bubble, then pc3.
- `stall` high 3 cycles mid-stream → `if_id_*` frozen; after release pc continues n+1, n+2 with no loss, no duplicate, no bubble.
- `redirect_en`=1, `redirect_pc`=20, coinciding with `stall`=1 → two bubbles, then `if_id_pc`=20, valid; skid contents never appear.
- Fetch runs to address 31, one-word → `pc` wraps to 0 and `if_id_pc` 31 is followed by 0.
- `rst_n` low for one cycle during a stall with skid full → all outputs at reset values immediately; refetch from RESET_PC.
